// File: rtl/uart_rx_core.sv
// uart_rx_core
//   UART receiver: 2-flop input synchronizer, 16x oversampling with a
//   3-sample majority vote at mid-bit, parity and stop-bit checking, and a
//   small receive FIFO drained over a valid/ready handshake.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-low reset
//   rx            serial input, idles high, asynchronous to clk
//   rx_data       data word at the FIFO head (0 when empty)
//   rx_parity_err parity-error flag of the head entry
//   rx_frame_err  framing-error flag of the head entry
//   rx_valid      FIFO not empty
//   rx_ready      consumer accepts the head entry when rx_valid && rx_ready
//   overrun       1-clock pulse when a completed frame is dropped (FIFO full)
//   busy          receiver FSM is not idle
module uart_rx_core #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_WIDTH + 2;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_DAT = 4'(DATA_WIDTH);
  localparam logic [3:0]       LAST_STP = 4'(STOP_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  // control state
  logic                  rx_meta_q, rx_s_q;
  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            os_q, os_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  // datapath state (not reset)
  logic                  s7_q, s7_d, s8_q, s8_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d;
  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];

  logic             tick, sample_tick, wrap_tick, bit_val;
  logic             push, pop, wr_en, full;
  logic [ENT_W-1:0] push_word, head;

  assign tick        = (state_q != S_IDLE) && (div_q == DIV_MAX);
  assign sample_tick = tick && (os_q == 4'd9);
  assign wrap_tick   = tick && (os_q == 4'd15);
  // majority of the samples taken at os_cnt 7, 8 and the current one at 9
  assign bit_val     = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
  assign push_word   = {shift_q, perr_q, ferr_q | ~bit_val};

  // Receiver FSM next state
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    os_d      = os_q;
    bit_cnt_d = bit_cnt_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    push      = 1'b0;

    if (state_q == S_IDLE) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
      os_d  = os_q + 4'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (tick && os_q == 4'd7) s7_d = rx_s_q;
    if (tick && os_q == 4'd8) s8_d = rx_s_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          os_d      = '0;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      S_START: begin
        if (sample_tick && bit_val) begin
          state_d = S_IDLE;  // start bit did not hold to mid-bit: glitch
        end else if (wrap_tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};  // LSB first
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (wrap_tick && bit_cnt_q == LAST_DAT) begin
          state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_PARITY: begin
        // 1 when data plus parity bit do not give the configured parity
        if (sample_tick) perr_d = (^shift_q) ^ bit_val ^ PAR_ODD;
        if (wrap_tick) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          if (bit_cnt_q == LAST_STP) begin
            // leave at mid-stop-bit so a following start edge is not missed
            push    = 1'b1;
            state_d = bit_val ? S_IDLE : S_WAIT_HIGH;
          end else begin
            ferr_d    = ferr_q | ~bit_val;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control
  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = rx_valid && rx_ready;
    wr_en    = push && (!full || pop);
    overrun  = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      div_q     <= '0;
      os_q      <= '0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      div_q     <= div_d;
      os_q      <= os_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    s7_q    <= s7_d;
    s8_q    <= s8_d;
    shift_q <= shift_d;
    perr_q  <= perr_d;
    ferr_q  <= ferr_d;
    if (wr_en) mem_q[wr_ptr_q] <= push_word;
  end

  // head is gated by rx_valid so the uninitialised storage never shows
  assign rx_valid      = (count_q != '0);
  assign head          = mem_q[rd_ptr_q];
  assign rx_data       = rx_valid ? head[ENT_W-1:2] : '0;
  assign rx_parity_err = rx_valid & head[1];
  assign rx_frame_err  = rx_valid & head[0];
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  localparam int BIT = 64;  // 16 * CLK_DIV clocks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_valid, overrun, busy;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_DIV(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun), .busy(busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   overrun_cnt = 0;
  int   vld_run = 0;
  int   last_run = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted transfer
  always @(negedge clk) begin
    if (overrun) overrun_cnt++;
    if (rx_valid) vld_run++;
    else begin
      if (vld_run != 0) last_run = vld_run;
      vld_run = 0;
    end
    if (rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got %0h exp none", {rx_data, rx_parity_err, rx_frame_err});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_word", {22'd0, rx_data, rx_parity_err, rx_frame_err}, {22'd0, e});
      end
    end
  end

  initial begin
    #600us;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stopv);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stopv);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int ov0;
    // reset state
    repeat (5) @(negedge clk);
    chk("reset_outputs", {rx_data, rx_parity_err, rx_frame_err, rx_valid, overrun, busy}, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 0xA5, correct even parity
    exp_q.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_drain("drain_a5");
    chk("valid_one_clock", last_run, 1);

    // 0x3C with wrong parity bit
    exp_q.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_drain("drain_3c");

    // 0x00 with stop bit 0, line stays low for 3 bit periods
    exp_q.push_back('{8'h00, 1'b0, 1'b1});
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    chk("busy_wait_high", busy, 1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy_after_high", busy, 0);
    exp_q.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b0, 1'b1);
    wait_drain("drain_81");

    // start-bit glitch of 12 clocks
    rx = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_busy_rise", busy, 1);
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    chk("glitch_busy_fall", busy, 0);
    repeat (BIT) @(negedge clk);
    chk("glitch_no_valid", rx_valid, 0);

    // overrun: 5 back-to-back frames with no consumer
    set_ready(1'b0);
    ov0 = overrun_cnt;
    exp_q.push_back('{8'h01, 1'b0, 1'b0});
    exp_q.push_back('{8'h02, 1'b0, 1'b0});
    exp_q.push_back('{8'h03, 1'b0, 1'b0});
    exp_q.push_back('{8'h04, 1'b0, 1'b0});
    send_frame(8'h01, 1'b1, 1'b1);
    chk("head_first", rx_data, 8'h01);
    send_frame(8'h02, 1'b1, 1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    send_frame(8'h04, 1'b1, 1'b1);
    chk("no_overrun_yet", overrun_cnt - ov0, 0);
    send_frame(8'h05, 1'b0, 1'b1);
    chk("overrun_once", overrun_cnt - ov0, 1);
    chk("head_stable", rx_data, 8'h01);
    set_ready(1'b1);
    wait_drain("drain_overrun");
    chk("empty_after_drain", rx_valid, 0);

    // reset in the middle of 0x55
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("busy_mid_frame", busy, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("outputs_in_reset", {rx_data, rx_parity_err, rx_frame_err, rx_valid, overrun, busy}, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (BIT) @(negedge clk);
    chk("no_partial_word", rx_valid, 0);
    exp_q.push_back('{8'h66, 1'b0, 1'b0});
    send_frame(8'h66, 1'b0, 1'b1);
    wait_drain("drain_66");
    chk("final_empty", rx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
